simd_issue_sequencer: RTL and testbench

//  Decode/issue controller between instruction fetch and the SIMD AES datapath.

---
 rtl/simd_pkg.sv | 26 ++
 rtl/simd_issue_sequencer.sv | 118 +++++++++++
 tb/tb_simd_issue_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD issue path: instruction field layout,
// opcode constants, sequencer state encoding and vector-op classification.
package simd_pkg;

  localparam int OPC_LSB = 27;
  localparam int OPC_W   = 5;
  localparam int P1_LSB  = 12;
  localparam int P1_W    = 15;
  localparam int P2_LSB  = 2;
  localparam int P2_W    = 10;

  localparam logic [4:0] OP_BR     = 5'b11000;
  localparam logic [1:0] VEC_CLASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALAR = 2'd1,
    VEC    = 2'd2
  } issue_state_t;

  // The 11xxx opcode space is vector, except the branch that shares its prefix.
  function automatic logic is_vector_op(input logic [4:0] opcode);
    return (opcode[4:3] == VEC_CLASS) && (opcode != OP_BR);
  endfunction

endpackage

// File: rtl/simd_issue_sequencer.sv
// Decode/issue sequencer between fetch and the SIMD AES datapath: latches one
// instruction, issues scalar ops as one beat and vector ops as VL+1 beats.
module simd_issue_sequencer
  import simd_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int BEAT_LANES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_opcode,
  output logic [14:0]      out_p1,
  output logic [9:0]       out_p2,
  output logic             out_is_vec,
  output logic [1:0]       out_beat,
  output logic [4:0]       out_lane_base,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] issue_count
);

  // state | meaning
  // IDLE   | no instruction held, fetch may present a new one
  // SCALAR | scalar op held, single beat waiting for out_ready
  // VEC    | vector op held, issuing beats 0..VL
  issue_state_t     state_q, state_d;
  logic [4:0]       opcode_q, opcode_d;
  logic [14:0]      p1_q, p1_d;
  logic [9:0]       p2_q, p2_d;
  logic [1:0]       beat_q, beat_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [4:0]  in_opcode;
  logic        completing;
  logic        accept;
  logic        unused_rsvd;

  assign in_opcode   = in_instr[OPC_LSB +: OPC_W];
  assign unused_rsvd = ^in_instr[1:0];

  assign out_valid     = (state_q != IDLE);
  assign busy          = (state_q != IDLE);
  assign out_is_vec    = (state_q == VEC);
  assign out_opcode    = opcode_q;
  assign out_p1        = p1_q;
  assign out_p2        = p2_q;
  assign out_beat      = beat_q;
  assign out_lane_base = 5'((int'(beat_q) * BEAT_LANES) % LANES);
  assign issue_count   = count_q;

  assign completing = out_valid & out_ready & out_last;
  assign in_ready   = ((state_q == IDLE) | completing) & ~flush & ~rst;
  assign accept     = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    beat_d   = beat_q;
    count_d  = count_q;
    out_last = 1'b0;

    case (state_q)
      SCALAR:  out_last = 1'b1;
      VEC:     out_last = (beat_q == p2_q[1:0]);
      default: out_last = 1'b0;
    endcase

    // Flush drops the held instruction, including a beat completing this cycle.
    if (flush) begin
      state_d = IDLE;
      beat_d  = 2'd0;
    end else begin
      if (completing && (count_q != '1))
        count_d = count_q + CNT_W'(1);

      if (accept) begin
        opcode_d = in_opcode;
        p1_d     = in_instr[P1_LSB +: P1_W];
        p2_d     = in_instr[P2_LSB +: P2_W];
        beat_d   = 2'd0;
        state_d  = is_vector_op(in_opcode) ? VEC : SCALAR;
      end else if (completing) begin
        state_d = IDLE;
        beat_d  = 2'd0;
      end else if ((state_q == VEC) && out_ready) begin
        beat_d = beat_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      beat_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      beat_q   <= beat_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_simd_issue_sequencer.sv
// Self-checking bench for simd_issue_sequencer: directed scenarios plus random
// traffic compared against an instruction-level reference model.
module tb_simd_issue_sequencer;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, flush, out_ready;
  logic [31:0]      in_instr;
  logic             in_ready, out_valid, out_is_vec, out_last, busy;
  logic [4:0]       out_opcode, out_lane_base;
  logic [14:0]      out_p1;
  logic [9:0]       out_p2;
  logic [1:0]       out_beat;
  logic [CNT_W-1:0] issue_count;

  int compared   = 0;
  int mismatched = 0;

  simd_issue_sequencer #(.LANES(16), .BEAT_LANES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_opcode(out_opcode), .out_p1(out_p1),
    .out_p2(out_p2), .out_is_vec(out_is_vec), .out_beat(out_beat),
    .out_lane_base(out_lane_base), .out_last(out_last), .busy(busy),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently held and how far through it we are.
  logic        m_have;
  logic [4:0]  m_op;
  logic [14:0] m_p1;
  logic [9:0]  m_p2;
  int          m_beat;
  int          m_nbeats;
  int          m_count;

  function automatic logic m_isvec(input logic [4:0] op);
    return (op >= 5'd24) && (op != 5'd24);
  endfunction

  function automatic logic m_last();
    return m_have && (m_beat == m_nbeats - 1);
  endfunction

  function automatic logic exp_ready();
    return (!m_have || (out_ready && m_last())) && !flush && !rst;
  endfunction

  function automatic logic [45:0] exp_vec();
    logic [1:0] b;
    logic [4:0] lb;
    b  = 2'(m_beat);
    lb = 5'(m_beat * 4);
    return {m_have, m_op, m_p1, m_p2, m_have && m_isvec(m_op), b, lb,
            m_last(), m_have, 4'(m_count), exp_ready()};
  endfunction

  function automatic logic [45:0] act_vec();
    return {out_valid, out_opcode, out_p1, out_p2, out_is_vec, out_beat,
            out_lane_base, out_last, busy, issue_count, in_ready};
  endfunction

  function automatic void model_update();
    logic rdy, comp;
    rdy  = exp_ready();
    comp = m_have && out_ready && m_last();
    if (rst) begin
      m_have = 0; m_op = '0; m_p1 = '0; m_p2 = '0;
      m_beat = 0; m_nbeats = 1; m_count = 0;
    end else if (flush) begin
      m_have = 0; m_beat = 0;
    end else begin
      if (comp && m_count < CNT_MAX) m_count++;
      if (in_valid && rdy) begin
        m_op     = in_instr[31:27];
        m_p1     = in_instr[26:12];
        m_p2     = in_instr[11:2];
        m_have   = 1;
        m_beat   = 0;
        m_nbeats = m_isvec(m_op) ? int'(m_p2[1:0]) + 1 : 1;
      end else if (comp) begin
        m_have = 0; m_beat = 0;
      end else if (m_have && out_ready) begin
        m_beat++;
      end
    end
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] vl);
    logic [14:0] p1;
    logic [7:0]  p2h;
    logic [1:0]  rsv;
    p1  = 15'($urandom);
    p2h = 8'($urandom);
    rsv = 2'($urandom);
    return {op, p1, p2h, vl, rsv};
  endfunction

  task automatic drive(input logic r, input logic iv, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    rst = r; in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, mk(5'b00100, 2'd0), 1, 0);
      compared++;
      if (in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_in_ready cyc%0d: got %b expected 0", i, in_ready);
      end
      tick();
    end
    drive(0, 0, 32'd0, 0, 0);
    compared++;
    if (out_valid !== 1'b0 || issue_count !== '0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: valid %b count %0d busy %b expected 0 0 0",
               out_valid, issue_count, busy);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    compared++;
    if (act_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL reset_model: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_scalar();
    logic [31:0] ins;
    ins = mk(5'b00100, 2'($urandom));
    drive(0, 1, ins, 1, 0);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL scalar_accept: ready %b valid %b expected 1 0", in_ready, out_valid);
    end
    tick();
    drive(0, 0, 32'd0, 1, 0);
    compared++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_beat !== 2'd0 ||
        out_opcode !== 5'b00100 || out_is_vec !== 1'b0 || out_p2 !== ins[11:2]) begin
      mismatched++;
      $display("FAIL scalar_issue: valid %b last %b beat %0d op %b vec %b p2 %h expected 1 1 0 00100 0 %h",
               out_valid, out_last, out_beat, out_opcode, out_is_vec, out_p2, ins[11:2]);
    end
    tick();
    drive(0, 0, 32'd0, 1, 0);
    compared++;
    if (issue_count !== 4'd1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL scalar_count: count %0d valid %b expected 1 0", issue_count, out_valid);
    end
  endtask

  task automatic test_vector();
    logic [31:0] ins, nxt;
    ins = mk(5'b11010, 2'd3);
    nxt = mk(5'b00100, 2'd0);
    drive(0, 1, ins, 1, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      drive(0, 1, nxt, 1, 0);
      compared++;
      if (out_valid !== 1'b1 || out_beat !== 2'(b) || out_lane_base !== 5'(b * 4) ||
          out_last !== (b == 3) || in_ready !== (b == 3) || out_is_vec !== 1'b1) begin
        mismatched++;
        $display("FAIL vector_beat%0d: valid %b beat %0d base %0d last %b ready %b vec %b",
                 b, out_valid, out_beat, out_lane_base, out_last, in_ready, out_is_vec);
      end
      compared++;
      if (act_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL vector_model beat%0d: got %h expected %h", b, act_vec(), exp_vec());
      end
      tick();
    end
    drive(0, 0, 32'd0, 1, 0);
    compared++;
    if (out_valid !== 1'b1 || out_opcode !== 5'b00100 || out_p1 !== nxt[26:12] ||
        issue_count !== 4'd2) begin
      mismatched++;
      $display("FAIL vector_no_bubble: valid %b op %b count %0d expected 1 00100 2",
               out_valid, out_opcode, issue_count);
    end
    tick();
    drive(0, 0, 32'd0, 1, 0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] ins;
    ins = mk(5'b11100, 2'd1);
    drive(0, 1, ins, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'd0, 0, 0);
      compared++;
      if (out_valid !== 1'b1 || out_beat !== 2'd0 || out_opcode !== ins[31:27] ||
          out_p1 !== ins[26:12] || out_p2 !== ins[11:2] || out_last !== 1'b0) begin
        mismatched++;
        $display("FAIL backpressure_hold cyc%0d: valid %b beat %0d op %b p1 %h p2 %h last %b",
                 i, out_valid, out_beat, out_opcode, out_p1, out_p2, out_last);
      end
      tick();
    end
    for (int b = 0; b < 2; b++) begin
      drive(0, 0, 32'd0, 1, 0);
      compared++;
      if (out_beat !== 2'(b) || out_last !== (b == 1)) begin
        mismatched++;
        $display("FAIL backpressure_beat%0d: beat %0d last %b", b, out_beat, out_last);
      end
      tick();
    end
    drive(0, 0, 32'd0, 1, 0);
    compared++;
    if (issue_count !== 4'd4 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_count: count %0d valid %b expected 4 0", issue_count, out_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] ins, nxt;
    ins = mk(5'b11111, 2'd2);
    nxt = mk(5'b00001, 2'd0);
    drive(0, 1, ins, 1, 0);
    tick();
    drive(0, 0, 32'd0, 1, 0);
    tick();
    drive(0, 1, nxt, 1, 1);
    compared++;
    if (in_ready !== 1'b0 || out_beat !== 2'd1) begin
      mismatched++;
      $display("FAIL flush_cycle: ready %b beat %0d expected 0 1", in_ready, out_beat);
    end
    tick();
    drive(0, 0, 32'd0, 1, 0);
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_beat !== 2'd0 ||
        issue_count !== 4'd4 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_after: valid %b busy %b beat %0d count %0d ready %b expected 0 0 0 4 1",
               out_valid, busy, out_beat, issue_count, in_ready);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int c = 0; c < 400; c++) begin
      op = 5'($urandom);
      if ($urandom_range(0, 1) == 1) op[4:3] = 2'b11;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
            mk(op, 2'($urandom)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
      compared++;
      if (act_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL random cyc%0d: got %h expected %h", c, act_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    int  n_acc;
    int  cyc;
    logic iv;
    drive(1, 0, 32'd0, 0, 0);
    tick();
    n_acc = 0;
    cyc   = 0;
    while ((n_acc < 17 || m_have) && cyc < 60) begin
      iv = (n_acc < 17);
      drive(0, iv, mk(5'b00100, 2'($urandom)), 1, 0);
      compared++;
      if (act_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL saturation_model cyc%0d: got %h expected %h", cyc, act_vec(), exp_vec());
      end
      if (iv && exp_ready()) n_acc++;
      tick();
      cyc++;
    end
    drive(0, 0, 32'd0, 1, 0);
    compared++;
    if (cyc >= 60 || issue_count !== 4'd15) begin
      mismatched++;
      $display("FAIL saturation: count %0d accepted %0d cycles %0d expected 15 17 <60",
               issue_count, n_acc, cyc);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
    m_have = 0; m_op = '0; m_p1 = '0; m_p2 = '0; m_beat = 0; m_nbeats = 1; m_count = 0;
    @(negedge clk);
    test_reset();
    test_scalar();
    test_vector();
    test_backpressure();
    test_flush();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
